axi_master: RTL and testbench

- Single-outstanding AXI4 initiator that turns a simple command/stream interface into AXI4 write and read bursts.
- It pairs with the team's axi_slave memory model (no ID signals) as the bus driver used by datapath blocks.
- Write data is streamed in from the user side, and read data is streamed out to the user side.
- Illegal commands are rejected locally, and bus responses are summarised per transaction.

---
 rtl/axi_master_if.sv | 58 +++++
 rtl/axi_master.sv | 193 +++++++++++++++++++
 tb/tb_axi_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_if.sv
// AXI4 bus bundle (no ID signals) between axi_master and a memory slave.
// master drives AW/W/AR and the B/R readies; slave drives the rest.
interface axi_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_master.sv
// Single-outstanding AXI4 initiator: command/stream side to AXI bursts.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic [DATA_WIDTH-1:0]   usr_wdata,
  input  logic [DATA_WIDTH/8-1:0] usr_wstrb,
  input  logic                    usr_wvalid,
  output logic                    usr_wready,
  output logic [DATA_WIDTH-1:0]   usr_rdata,
  output logic                    usr_rlast,
  output logic                    usr_rvalid,
  input  logic                    usr_rready,
  output logic                    done,
  output logic [1:0]              resp,
  output logic                    err_local,
  output logic                    timeout,
  axi_master_if.master            axi
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_AW, S_W,
    S_B, S_AR, S_R, S_DONE
  } state_t;

  localparam int SMAX = $clog2(DATA_WIDTH/8);

  state_t state, state_nx;

  logic                  c_write;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [7:0]            c_len;
  logic [2:0]            c_size;
  logic [1:0]            c_burst;
  logic [8:0]            cnt;
  logic [1:0]            acc;
  logic                  r_err;
  logic [1:0]            resp_q;
  logic                  err_q;
  logic                  to_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic to_hit;
  logic bad, wrap_ok;
  logic [ADDR_WIDTH-1:0] amask;
  logic [8:0]            len_p1;
  logic [12:0]           end_off;
  logic [1:0]            r_max, r_final;

  assign amask   = ({{(ADDR_WIDTH-1){1'b0}}, 1'b1} << c_size)
                 - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign len_p1  = {1'b0, c_len} + 9'd1;
  assign end_off = {1'b0, c_addr[11:0]}
                 + ({4'b0, len_p1} << c_size);
  assign wrap_ok = (c_len == 8'd1) || (c_len == 8'd3)
                || (c_len == 8'd7) || (c_len == 8'd15);

  assign bad = (c_burst == 2'b11)
            || (|(c_addr & amask))
            || (c_size > 3'(SMAX))
            || (c_burst == 2'b10 && !wrap_ok)
            || (c_burst == 2'b01 && end_off > 13'd4096);

  assign aw_hs = (state == S_AW) && axi.AWREADY;
  assign w_hs  = (state == S_W) && usr_wvalid && axi.WREADY;
  assign b_hs  = (state == S_B) && axi.BVALID;
  assign ar_hs = (state == S_AR) && axi.ARREADY;
  assign r_hs  = (state == S_R) && axi.RVALID && usr_rready;

  // a wrong-length burst overrides whatever RRESP reported
  assign r_max   = (axi.RRESP > acc) ? axi.RRESP : acc;
  assign r_final = (r_err || (axi.RLAST && cnt > 9'd1))
                 ? 2'b10 : r_max;

  assign cmd_ready   = (state == S_IDLE);
  assign axi.AWVALID = (state == S_AW);
  assign axi.AWADDR  = c_addr;
  assign axi.AWLEN   = c_len;
  assign axi.AWSIZE  = c_size;
  assign axi.AWBURST = c_burst;
  assign axi.ARVALID = (state == S_AR);
  assign axi.ARADDR  = c_addr;
  assign axi.ARLEN   = c_len;
  assign axi.ARSIZE  = c_size;
  assign axi.ARBURST = c_burst;
  assign axi.WVALID  = (state == S_W) && usr_wvalid;
  assign axi.WDATA   = usr_wdata;
  assign axi.WSTRB   = usr_wstrb;
  assign axi.WLAST   = (state == S_W) && (cnt == 9'd1);
  assign usr_wready  = (state == S_W) && axi.WREADY;
  assign axi.BREADY  = (state == S_B);
  assign axi.RREADY  = (state == S_R) && usr_rready;
  assign usr_rvalid  = (state == S_R) && axi.RVALID;
  assign usr_rdata   = axi.RDATA;
  assign usr_rlast   = (state == S_R) && axi.RLAST;
  assign done        = (state == S_DONE);
  assign resp        = resp_q;
  assign err_local   = err_q;
  assign timeout     = to_q;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd;
  logic busy, any_hs;
  assign busy = state inside {S_AW, S_W, S_B, S_AR, S_R};
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  always_ff @(posedge ACLK) begin
    if (ARESET || !busy || any_hs) wd <= '0;
    else wd <= wd + 1'b1;
  end
  assign to_hit = busy && !any_hs
               && (wd == WDW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYCLES == 0);
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_nx = S_CHECK;
      S_CHECK: state_nx = bad ? S_DONE
                        : (c_write ? S_AW : S_AR);
      S_AW:    if (aw_hs) state_nx = S_W;
      S_W:     if (w_hs && cnt == 9'd1) state_nx = S_B;
      S_B:     if (b_hs) state_nx = S_DONE;
      S_AR:    if (ar_hs) state_nx = S_R;
      S_R:     if (r_hs && axi.RLAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (to_hit) state_nx = S_DONE;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= S_IDLE;
      c_write <= 1'b0;
      c_addr  <= '0;
      c_len   <= '0;
      c_size  <= '0;
      c_burst <= '0;
      cnt     <= '0;
      acc     <= '0;
      r_err   <= 1'b0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && cmd_valid) begin
        c_write <= cmd_write;
        c_addr  <= cmd_addr;
        c_len   <= cmd_len;
        c_size  <= cmd_size;
        c_burst <= cmd_burst;
      end
      if (state == S_CHECK) begin
        cnt   <= len_p1;
        acc   <= '0;
        r_err <= 1'b0;
      end
      if (w_hs) cnt <= cnt - 9'd1;
      // beats past the expected count keep flowing until RLAST
      if (r_hs) begin
        if (cnt != 9'd0) cnt <= cnt - 9'd1;
        acc <= r_max;
        if (axi.RLAST ? (cnt > 9'd1) : (cnt <= 9'd1))
          r_err <= 1'b1;
      end
      if (state_nx == S_DONE && state != S_DONE) begin
        err_q <= (state == S_CHECK);
        to_q  <= to_hit;
        if (to_hit || state == S_CHECK) resp_q <= 2'b10;
        else if (state == S_B) resp_q <= axi.BRESP;
        else resp_q <= r_final;
      end
    end
  end

endmodule

// File: tb/tb_axi_master.sv
// Randomized bench for axi_master with a byte-memory slave model.
// Expected addresses, legality and responses come from burst arithmetic.
module tb_axi_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic [DW-1:0] usr_wdata, usr_rdata;
  logic [3:0]    usr_wstrb;
  logic          usr_wvalid, usr_wready;
  logic          usr_rlast, usr_rvalid, usr_rready;
  logic          done, err_local, timeout;
  logic [1:0]    resp;

  axi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst),
    .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
    .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
    .usr_rdata(usr_rdata), .usr_rlast(usr_rlast),
    .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
    .done(done), .resp(resp),
    .err_local(err_local), .timeout(timeout),
    .axi(bus.master)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass = 0;
  bit [7:0] mem [int];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic bit legal(int addr, int len,
                               int size, int burst);
    int nb;
    nb = 1 << size;
    if (burst == 3) return 1'b0;
    if (size > 2) return 1'b0;
    if (addr % nb != 0) return 1'b0;
    if (burst == 2 && !(len == 1 || len == 3 ||
                        len == 7 || len == 15)) return 1'b0;
    if (burst == 1 && (addr % 4096) + (len + 1) * nb > 4096)
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic int beat_addr(int addr, int len, int size,
                                   int burst, int i);
    int nb, wb, base;
    nb = 1 << size;
    if (burst == 0) return addr;
    if (burst == 1) return addr + i * nb;
    wb = (len + 1) * nb;
    base = addr - addr % wb;
    return base + (addr - base + i * nb) % wb;
  endfunction

  function automatic logic [31:0] rd_word(int a);
    logic [31:0] w;
    int wa;
    wa = a & ~3;
    for (int j = 0; j < 4; j++)
      w[8*j +: 8] = mem.exists(wa + j) ? mem[wa + j] : 8'h00;
    return w;
  endfunction

  // mode: 0 OKAY, 1 SLVERR, 2 early RLAST, 3 late RLAST,
  //       4 reset on W beat 2, 5 random OKAY/EXOKAY
  task automatic xfer(input bit wr, input int addr, input int len,
                      input int size, input int burst,
                      input int mode, input bit seq);
    bit ok;
    int t, ba, nbeats, mx;
    logic [1:0] rr, exp_resp;
    logic [31:0] d;
    logic [3:0] s;
    ok = legal(addr, len, size, burst);
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr;
    cmd_addr = 32'(addr); cmd_len = 8'(len);
    cmd_size = 3'(size); cmd_burst = 2'(burst);
    #1 check("cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    @(negedge ACLK);
    #1;
    if (!ok) begin
      check("rej_valid", {bus.AWVALID, bus.ARVALID}, 64'd0);
      check("rej_status", {done, err_local, timeout, resp},
            {1'b1, 1'b1, 1'b0, 2'b10});
      return;
    end
    check("addr_latency", wr ? bus.AWVALID : bus.ARVALID, 64'd1);
    repeat ($urandom_range(0, 3)) @(negedge ACLK);
    if (wr) bus.AWREADY = 1'b1; else bus.ARREADY = 1'b1;
    #1;
    if (wr)
      check("aw_fields",
            {bus.AWVALID, bus.AWADDR, bus.AWLEN,
             bus.AWSIZE, bus.AWBURST},
            {1'b1, 32'(addr), 8'(len), 3'(size), 2'(burst)});
    else
      check("ar_fields",
            {bus.ARVALID, bus.ARADDR, bus.ARLEN,
             bus.ARSIZE, bus.ARBURST},
            {1'b1, 32'(addr), 8'(len), 3'(size), 2'(burst)});
    @(negedge ACLK);
    bus.AWREADY = 1'b0; bus.ARREADY = 1'b0;

    if (wr) begin
      for (int i = 0; i <= len; i++) begin
        d = seq ? 32'hA0 + 32'(i) : $urandom;
        s = seq ? 4'hF : 4'($urandom);
        usr_wdata = d; usr_wstrb = s;
        if (mode == 4 && i == 1) begin
          ARESET = 1'b1; usr_wvalid = 1'b1; bus.WREADY = 1'b1;
          @(negedge ACLK);
          ARESET = 1'b0;
          #1;
          check("rst_outputs",
                {bus.AWVALID, bus.WVALID, bus.BREADY,
                 bus.ARVALID, bus.RREADY, done, cmd_ready},
                64'd1);
          usr_wvalid = 1'b0; bus.WREADY = 1'b0;
          return;
        end
        t = 0;
        forever begin
          usr_wvalid = (t > 3) || ($urandom_range(0, 3) != 0);
          bus.WREADY = (t > 3) || ($urandom_range(0, 3) != 0);
          #1;
          if (usr_wvalid && bus.WREADY) break;
          @(negedge ACLK);
          t++;
        end
        check("w_beat",
              {bus.WVALID, bus.WLAST, usr_wready,
               bus.WDATA, bus.WSTRB},
              {1'b1, 1'(i == len), 1'b1, d, s});
        ba = beat_addr(addr, len, size, burst, i);
        for (int j = 0; j < 4; j++)
          if (s[j]) mem[(ba & ~3) + j] = d[8*j +: 8];
        @(negedge ACLK);
      end
      usr_wvalid = 1'b0; bus.WREADY = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
      rr = (mode == 1) ? 2'b10
         : (mode == 5) ? 2'($urandom_range(0, 1)) : 2'b00;
      exp_resp = rr;
      bus.BRESP = rr; bus.BVALID = 1'b1;
      #1 check("bready", 64'(bus.BREADY), 64'd1);
      @(negedge ACLK);
      bus.BVALID = 1'b0;
    end else begin
      nbeats = (mode == 2) ? 2 : (mode == 3) ? len + 2 : len + 1;
      mx = 0;
      for (int i = 0; i < nbeats; i++) begin
        ba = beat_addr(addr, len, size, burst, i);
        d = rd_word(ba);
        rr = (mode == 1 && i == len) ? 2'b10
           : (mode == 5) ? 2'($urandom_range(0, 1)) : 2'b00;
        bus.RDATA = d; bus.RRESP = rr;
        bus.RLAST = (i == nbeats - 1);
        t = 0;
        forever begin
          bus.RVALID = (t > 3) || ($urandom_range(0, 3) != 0);
          usr_rready = (t > 3) || ($urandom_range(0, 3) != 0);
          #1;
          if (bus.RVALID && usr_rready) break;
          @(negedge ACLK);
          t++;
        end
        check("r_beat",
              {usr_rvalid, usr_rlast, bus.RREADY, usr_rdata},
              {1'b1, 1'(i == nbeats - 1), 1'b1, d});
        if (int'(rr) > mx) mx = int'(rr);
        @(negedge ACLK);
      end
      bus.RVALID = 1'b0; usr_rready = 1'b0; bus.RLAST = 1'b0;
      exp_resp = (mode == 2 || mode == 3) ? 2'b10 : 2'(mx);
    end
    #1;
    check("done_status", {done, err_local, timeout, resp},
          {1'b1, 1'b0, 1'b0, exp_resp});
    @(negedge ACLK);
    #1 check("status_hold", {done, resp}, {1'b0, exp_resp});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    usr_wdata = '0; usr_wstrb = '0; usr_wvalid = 1'b0;
    usr_rready = 1'b0;
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    bus.BRESP = 2'b00; bus.BVALID = 1'b0;
    bus.ARREADY = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00;
    bus.RLAST = 1'b0; bus.RVALID = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    check("reset_valids",
          {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID,
           bus.RREADY, bus.WLAST, usr_rvalid, usr_wready},
          64'd0);
    check("reset_status",
          {cmd_ready, done, err_local, timeout, resp},
          {1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
    check("reset_addr", {bus.AWADDR, bus.AWLEN, bus.ARADDR},
          64'd0);
    ARESET = 1'b0;

    xfer(1'b1, 'h10, 3, 2, 1, 0, 1'b1);
    xfer(1'b0, 'h10, 3, 2, 1, 0, 1'b0);
    xfer(1'b0, 'h18, 3, 2, 2, 0, 1'b0);
    xfer(1'b1, 'hFF8, 3, 2, 1, 0, 1'b0);
    xfer(1'b1, 'h10, 3, 2, 3, 0, 1'b0);
    xfer(1'b1, 'h12, 3, 2, 1, 0, 1'b0);
    xfer(1'b0, 'h20, 0, 3, 1, 0, 1'b0);
    xfer(1'b0, 'h20, 2, 2, 2, 0, 1'b0);
    xfer(1'b1, 'hFFC, 0, 2, 1, 0, 1'b0);
    xfer(1'b1, 'h80, 3, 2, 1, 1, 1'b0);
    xfer(1'b0, 'h10, 3, 2, 1, 1, 1'b0);
    xfer(1'b0, 'h10, 3, 2, 1, 2, 1'b0);
    xfer(1'b0, 'h10, 1, 2, 1, 3, 1'b0);
    xfer(1'b1, 'h40, 3, 2, 1, 4, 1'b0);
    xfer(1'b1, 'h40, 3, 2, 1, 0, 1'b0);
    xfer(1'b0, 'h40, 3, 2, 1, 0, 1'b0);
    xfer(1'b0, 'h44, 0, 2, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int a, l, s, b, m, r;
      bit w;
      w = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      b = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (b == 2) begin
        l = (1 << $urandom_range(1, 4)) - 1;
        if ($urandom_range(0, 7) == 0) l = 2;
      end else begin
        l = ($urandom_range(0, 19) == 0) ? 255
          : $urandom_range(0, 15);
      end
      a = ($urandom_range(0, 4) == 0)
        ? 4096 - $urandom_range(1, 64) : $urandom_range(0, 8191);
      if ($urandom_range(0, 7) != 0) a = a & ~((1 << s) - 1);
      r = $urandom_range(0, 5);
      m = 5;
      if (r == 0) m = 1;
      else if (!w && r == 1 && l >= 2) m = 2;
      else if (!w && r == 2) m = 3;
      xfer(w, a, l, s, b, m, 1'b0);
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    begin
      int t;
      t = 0;
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100;
      cmd_len = 8'd0; cmd_size = 3'd2; cmd_burst = 2'b01;
      @(negedge ACLK);
      cmd_valid = 1'b0;
      #1;
      while (!done && t < 40) begin
        @(negedge ACLK);
        #1;
        t++;
      end
      check("to_seen", 64'(done), 64'd1);
      check("to_status", {timeout, err_local, resp},
            {1'b1, 1'b0, 2'b10});
      @(negedge ACLK);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
